// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared constants, key classes and helpers for the calculator
// Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam int DATA_W  = 14;
    localparam int MAX_VAL = 9999;

    // Operands stop accepting digits once they reach four digits.
    localparam logic [DATA_W-1:0] DIGIT_LIMIT = 14'd1000;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'd10;
    localparam logic [3:0] KEY_SUB       = 4'd11;
    localparam logic [3:0] KEY_MULT      = 4'd12;
    localparam logic [3:0] KEY_EQ        = 4'd13;
    localparam logic [3:0] KEY_CLR       = 4'd14;
    localparam logic [3:0] KEY_NOP       = 4'd15;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;

    localparam logic [2:0] ST_ENTER_A = 3'd0;
    localparam logic [2:0] ST_ENTER_B = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_SHOW    = 3'd4;

    typedef enum logic [2:0] {
        KC_NONE  = 3'd0,
        KC_DIGIT = 3'd1,
        KC_OP    = 3'd2,
        KC_EQ    = 3'd3,
        KC_CLR   = 3'd4
    } key_class_e;

    function automatic key_class_e decode_key(input logic valid, input logic [3:0] code);
        key_class_e kc;
        kc = KC_NONE;
        if (valid) begin
            if (code <= KEY_DIGIT_MAX)                        kc = KC_DIGIT;
            else if ((code >= KEY_ADD) && (code <= KEY_MULT)) kc = KC_OP;
            else if (code == KEY_EQ)                          kc = KC_EQ;
            else if (code == KEY_CLR)                         kc = KC_CLR;
            else                                              kc = KC_NONE;
        end
        return kc;
    endfunction

    // Operator keys are contiguous, so the ALU op is the offset from KEY_ADD.
    function automatic logic [1:0] key_to_op(input logic [3:0] code);
        logic [3:0] offs;
        offs = code - KEY_ADD;
        return offs[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_accum.sv
`default_nettype none
// ============================================================================
// Module   : digit_accum
// Purpose  : Decimal operand accumulator (value*10+digit) with 4-digit limit
// Revision : 1.0  initial release
// ============================================================================
module digit_accum
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              digit_en,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0] r_value;
    logic [DATA_W-1:0] w_times10;
    logic [DATA_W-1:0] w_next;

    // Below the limit the largest result is 999*10+9, which fits in DATA_W.
    assign w_times10 = (r_value << 3) + (r_value << 1);
    assign w_next    = w_times10 + {{(DATA_W-4){1'b0}}, digit};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (digit_en && (r_value < DIGIT_LIMIT)) begin
            r_value <= w_next;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/calc_controller.sv
`default_nettype none
// ============================================================================
// Module   : calc_controller
// Purpose  : Keypad calculator sequencer driving an external registered ALU
// Revision : 1.0  initial release
// ============================================================================
module calc_controller
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic [DATA_W-1:0] alu_result,
    output logic [1:0]        alu_op,
    output logic              alu_eq_en,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] display_val,
    output logic              busy
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        r_alu_op;
    logic              r_b_entered;
    logic [DATA_W-1:0] r_result;

    key_class_e        w_kc;
    logic              w_clr;
    logic [1:0]        w_key_op;

    logic              w_a_load;
    logic [DATA_W-1:0] w_a_load_val;
    logic              w_a_digit_en;
    logic              w_b_clear;
    logic              w_b_digit_en;
    logic              w_op_load;
    logic              w_bent_set;
    logic              w_bent_clr;

    logic [DATA_W-1:0] w_a_val;
    logic [DATA_W-1:0] w_b_val;

    assign w_kc     = decode_key(key_valid, key_code);
    assign w_clr    = (w_kc == KC_CLR);
    assign w_key_op = key_to_op(key_code);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ENTER_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear wins from every state, including EXEC/WAIT.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = ST_ENTER_A;
        end else begin
            case (r_state)
                ST_ENTER_A: if (w_kc == KC_OP) w_state_nxt = ST_ENTER_B;
                ST_ENTER_B: if (w_kc == KC_EQ) w_state_nxt = ST_EXEC;
                ST_EXEC:    w_state_nxt = ST_WAIT;
                ST_WAIT:    w_state_nxt = ST_SHOW;
                ST_SHOW: begin
                    if (w_kc == KC_DIGIT)   w_state_nxt = ST_ENTER_A;
                    else if (w_kc == KC_OP) w_state_nxt = ST_ENTER_B;
                end
                default:    w_state_nxt = ST_ENTER_A;
            endcase
        end
    end

    // Operand and operator update strobes
    always_comb begin
        w_a_load     = 1'b0;
        w_a_load_val = r_result;
        w_a_digit_en = 1'b0;
        w_b_clear    = w_clr;
        w_b_digit_en = 1'b0;
        w_op_load    = 1'b0;
        w_bent_set   = 1'b0;
        w_bent_clr   = 1'b0;
        if (!w_clr) begin
            case (r_state)
                ST_ENTER_A: begin
                    w_a_digit_en = (w_kc == KC_DIGIT);
                    if (w_kc == KC_OP) begin
                        w_op_load  = 1'b1;
                        w_b_clear  = 1'b1;
                        w_bent_clr = 1'b1;
                    end
                end
                ST_ENTER_B: begin
                    w_b_digit_en = (w_kc == KC_DIGIT);
                    w_bent_set   = (w_kc == KC_DIGIT);
                    w_op_load    = (w_kc == KC_OP) && !r_b_entered;
                end
                ST_SHOW: begin
                    if (w_kc == KC_DIGIT) begin
                        w_a_load     = 1'b1;
                        w_a_load_val = {{(DATA_W-4){1'b0}}, key_code};
                        w_b_clear    = 1'b1;
                        w_bent_clr   = 1'b1;
                    end else if (w_kc == KC_OP) begin
                        // Chaining: the previous result becomes operand a.
                        w_a_load   = 1'b1;
                        w_op_load  = 1'b1;
                        w_b_clear  = 1'b1;
                        w_bent_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    digit_accum u_acc_a (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clr),
        .load     (w_a_load),
        .load_val (w_a_load_val),
        .digit_en (w_a_digit_en),
        .digit    (key_code),
        .value    (w_a_val)
    );

    digit_accum u_acc_b (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_b_clear),
        .load     (1'b0),
        .load_val ({DATA_W{1'b0}}),
        .digit_en (w_b_digit_en),
        .digit    (key_code),
        .value    (w_b_val)
    );

    // The ALU output is valid during WAIT, so it is captured on the WAIT->SHOW edge.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_alu_op    <= OP_ADD;
            r_b_entered <= 1'b0;
            r_result    <= '0;
        end else begin
            if (w_op_load) begin
                r_alu_op <= w_key_op;
            end
            if (w_bent_set) begin
                r_b_entered <= 1'b1;
            end else if (w_bent_clr) begin
                r_b_entered <= 1'b0;
            end
            if (r_state == ST_WAIT) begin
                r_result <= alu_result;
            end
        end
    end

    // Outputs
    always_comb begin
        alu_eq_en   = (r_state == ST_EXEC);
        busy        = (r_state == ST_EXEC) || (r_state == ST_WAIT);
        display_val = r_result;
        case (r_state)
            ST_ENTER_A: display_val = w_a_val;
            ST_ENTER_B: display_val = r_b_entered ? w_b_val : w_a_val;
            default:    display_val = r_result;
        endcase
    end

    assign alu_op = r_alu_op;
    assign alu_a  = w_a_val;
    assign alu_b  = w_b_val;

endmodule
`default_nettype wire

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 The block SHALL have the following ports, in this order:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset: synchronous, active-high.
- key_valid  input  1  one-cycle keypad strobe.
- key_code  input  4  keypad code, sampled only while key_valid=1.
- alu_result  input  14  registered result from the ALU.
- alu_op  output  2  ALU operation select: 0 add, 1 sub, 2 mult.
- alu_eq_en  output  1  ALU compute strobe.
- alu_a  output  14  ALU operand 1.
- alu_b  output  14  ALU operand 2.
- display_val  output  14  value shown on the 4-digit display.
- busy  output  1  high in EXEC and WAIT.

REQ-002 Key codes SHALL be decoded as follows:
- 0-9: digit.
- 10: add.
- 11: sub.
- 12: mult.
- 13: equals.
- 14: clear.
- 15: ignored.

Function
REQ-003 The FSM SHALL have exactly five states: ENTER_A, ENTER_B, EXEC, WAIT, SHOW.

REQ-004 Digit entry SHALL work as follows:
- In ENTER_A or ENTER_B, a digit updates the active operand to operand*10+digit.
- The digit is ignored if the operand is already >=1000 (4-digit limit).

REQ-005 In ENTER_A, an operator key SHALL:
- latch the operator into alu_op;
- clear b and b_entered;
- move to ENTER_B.

REQ-006 In ENTER_B, an operator key SHALL replace alu_op only while b_entered=0; otherwise it is ignored.

REQ-007 In ENTER_B, an equals key SHALL move to EXEC; equals in ENTER_A SHALL be ignored.

REQ-008 EXEC SHALL last exactly 1 cycle:
- alu_eq_en=1 for that cycle only;
- the next state is WAIT.

REQ-009 WAIT SHALL last exactly 1 cycle, covering the ALU's 1-cycle registered latency; the next state is SHOW.

REQ-010 On entry to SHOW, alu_result SHALL be captured into a result register in the same cycle, so the captured value is available 2 cycles after the EXEC cycle.

REQ-011 In SHOW:
- A digit d SHALL load a=d, b=0 and move to ENTER_A.
- An operator key SHALL load a=result, latch the operator, clear b and b_entered, and move to ENTER_B (chaining).
- Equals SHALL be ignored.

REQ-012 Key handling SHALL follow these rules:
- Every key except clear is ignored while busy=1.
- Clear (code 14) is accepted in every state; from EXEC or WAIT it aborts and the later ALU result is discarded.
- On clear: a=0, b=0, result=0, alu_op=0, and the next state is ENTER_A.

REQ-013 alu_a and alu_b SHALL be driven from the a and b registers at all times, and SHALL be stable from the EXEC cycle through the WAIT cycle.

REQ-014 display_val SHALL be:
- a in ENTER_A;
- b in ENTER_B when b_entered=1, otherwise a;
- the captured result in EXEC, WAIT and SHOW.

REQ-015 At most one key SHALL be consumed per cycle, with no key queueing; a key arriving in a cycle where it is ignored is lost.

REQ-016 All arithmetic SHALL be unsigned 14-bit. The controller performs no saturation; saturation and clamping are the ALU's responsibility.

Reset
REQ-017 While rst=1 on a clock edge, the block SHALL force:
- state=ENTER_A;
- a=0, b=0, result=0, b_entered=0;
- alu_op=0, alu_eq_en=0, busy=0, display_val=0.

REQ-018 Reset asserted mid-operation, including during EXEC or WAIT, SHALL take effect on the next edge; no alu_eq_en pulse may follow.

REQ-019 key_valid during reset SHALL be ignored.

Structure
REQ-020 A shared package calc_pkg SHALL hold:
- the key-code constants;
- the ALU op encodings (ADD=0, SUB=1, MULT=2);
- the FSM state encoding;
- the width constants (DATA_W=14, MAX_VAL=9999).

REQ-021 The decimal-entry logic SHALL be a sub-module digit_accum:
- inputs: clear, load, digit strobe, digit value;
- output: a 14-bit value;
- enforces the 1000 limit.

Two instances SHALL be used, one for operand a and one for operand b.

Verification
REQ-022 The bench SHALL instantiate the ALU and cover these directed scenarios:
- Keys 1,2,+,3,4,= -> alu_eq_en pulses once; display_val=46 exactly 2 cycles after EXEC; busy is high for 2 cycles.
- Keys 9,9,9,9,+,1,= -> result 9999 (ALU-saturated); key 5 pressed after 1,2,3,4 is ignored (value stays 1234).
- Keys 5,-,9,= -> display 0; then keys +,7,= -> chained result 7.
- Keys 3,+,-,4,= -> sub is used (operator replaced), display 0; keys 3,+,4,-,= -> add kept, display 7.
- Keys 2,*,3,= with clear asserted in the WAIT cycle -> state ENTER_A, display 0, captured result stays 0.
- rst pulsed during EXEC -> all outputs 0 next cycle and no further alu_eq_en pulse.
